// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone command master.
//   wbm_status_e : response status returned with every command
//   wbm_state_e  : master FSM states
//   WB_AW/WB_DW  : Wishbone address / data widths
package wbm_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    WBM_OK      = 2'd0,
    WBM_ERR     = 2'd1,
    WBM_TIMEOUT = 2'd2,
    WBM_RETRY   = 2'd3
  } wbm_status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } wbm_state_e;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   en       : count one cycle (master is in a bus cycle)
//   clr      : return count to zero (has priority over en)
//   expired  : counting and count has reached TIMEOUT_CYCLES-1
module wbm_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tmo_cnt <= '0;
    end else if (en) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // The final counted cycle is the one whose count equals TIMEOUT_CYCLES-1,
  // so cyc stays high for exactly TIMEOUT_CYCLES cycles.
  assign expired = en && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator.
// One command on the req_* channel produces one Wishbone cycle on wb_m2s_*/
// wb_s2m_* (plus rty retries) and one response on the rsp_* channel.
//   wb_clk, wb_rst          : clock, synchronous active-high reset
//   req_valid/req_ready     : command handshake; req_we/adr/dat/sel payload
//   rsp_valid/rsp_ready     : response handshake; rsp_dat/rsp_status payload
//   wb_m2s_adr/dat/sel/we   : bus request, loaded only when a bus cycle starts
//   wb_m2s_cyc/stb          : bus cycle strobes
//   wb_s2m_dat/ack/err/rty  : slave reply, only looked at in BUS
module wb_cmd_master
  import wbm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 3,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WB_AW-1:0] req_adr,
  input  logic [WB_DW-1:0] req_dat,
  input  logic [3:0]       req_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output wbm_status_e      rsp_status,
  output logic [WB_AW-1:0] wb_m2s_adr,
  output logic [WB_DW-1:0] wb_m2s_dat,
  output logic [3:0]       wb_m2s_sel,
  output logic             wb_m2s_we,
  output logic             wb_m2s_cyc,
  output logic             wb_m2s_stb,
  input  logic [WB_DW-1:0] wb_s2m_dat,
  input  logic             wb_s2m_ack,
  input  logic             wb_s2m_err,
  input  logic             wb_s2m_rty
);

  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  wbm_state_e     state, state_d;
  wbm_status_e    status_d;
  logic [RC_W-1:0] retry_cnt;
  logic           expired;
  logic           hs_req, hs_rsp, misaligned;
  logic           load_bus, set_rsp, capture, retry_inc;

  assign hs_req     = req_valid && req_ready;
  assign hs_rsp     = rsp_valid && rsp_ready;
  assign misaligned = (ALIGN_CHECK != 0) && (req_adr[1:0] != 2'b00);

  wbm_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .en      (state == BUS),
    .clr     (state != BUS),
    .expired (expired)
  );

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_d;
  end

  // Termination priority in BUS is err > ack > rty > timeout.
  always_comb begin
    state_d   = state;
    status_d  = WBM_OK;
    load_bus  = 1'b0;
    set_rsp   = 1'b0;
    capture   = 1'b0;
    retry_inc = 1'b0;
    case (state)
      IDLE: begin
        if (hs_req) begin
          if (misaligned) begin
            state_d  = RESP;
            status_d = WBM_ERR;
            set_rsp  = 1'b1;
          end else begin
            state_d  = BUS;
            load_bus = 1'b1;
          end
        end
      end
      BUS: begin
        if (wb_s2m_err) begin
          state_d  = RESP;
          status_d = WBM_ERR;
          set_rsp  = 1'b1;
        end else if (wb_s2m_ack) begin
          state_d  = RESP;
          status_d = WBM_OK;
          set_rsp  = 1'b1;
          capture  = !wb_m2s_we;
        end else if (wb_s2m_rty) begin
          if (retry_cnt == RC_W'(MAX_RETRY)) begin
            state_d  = RESP;
            status_d = WBM_RETRY;
            set_rsp  = 1'b1;
          end else begin
            state_d   = BACKOFF;
            retry_inc = 1'b1;
          end
        end else if (expired) begin
          state_d  = RESP;
          status_d = WBM_TIMEOUT;
          set_rsp  = 1'b1;
        end
      end
      BACKOFF: state_d = BUS;
      RESP: begin
        if (hs_rsp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so every port is registered.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= WBM_OK;
      wb_m2s_adr <= '0;
      wb_m2s_dat <= '0;
      wb_m2s_sel <= '0;
      wb_m2s_we  <= 1'b0;
      wb_m2s_cyc <= 1'b0;
      wb_m2s_stb <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      req_ready  <= (state_d == IDLE);
      rsp_valid  <= (state_d == RESP);
      wb_m2s_cyc <= (state_d == BUS);
      wb_m2s_stb <= (state_d == BUS);
      if (load_bus) begin
        wb_m2s_adr <= req_adr;
        wb_m2s_dat <= req_dat;
        wb_m2s_sel <= req_sel;
        wb_m2s_we  <= req_we;
      end
      // Writes and every non-ack termination return zero data.
      if (set_rsp) begin
        rsp_status <= status_d;
        rsp_dat    <= capture ? wb_s2m_dat : '0;
      end
      if (retry_inc) begin
        retry_cnt <= retry_cnt + RC_W'(1);
      end else if (state == RESP && hs_rsp) begin
        retry_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;
  import wbm_pkg::*;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  wbm_status_e rsp_status;
  logic [31:0] wb_m2s_adr;
  logic [31:0] wb_m2s_dat;
  logic [3:0]  wb_m2s_sel;
  logic        wb_m2s_we;
  logic        wb_m2s_cyc;
  logic        wb_m2s_stb;
  logic [31:0] wb_s2m_dat = '0;
  logic        wb_s2m_ack = 1'b0;
  logic        wb_s2m_err = 1'b0;
  logic        wb_s2m_rty = 1'b0;

  int checks = 0;
  int failures = 0;

  wb_cmd_master #(
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (3),
    .ALIGN_CHECK    (1)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_adr    (req_adr),
    .req_dat    (req_dat),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_status (rsp_status),
    .wb_m2s_adr (wb_m2s_adr),
    .wb_m2s_dat (wb_m2s_dat),
    .wb_m2s_sel (wb_m2s_sel),
    .wb_m2s_we  (wb_m2s_we),
    .wb_m2s_cyc (wb_m2s_cyc),
    .wb_m2s_stb (wb_m2s_stb),
    .wb_s2m_dat (wb_s2m_dat),
    .wb_s2m_ack (wb_s2m_ack),
    .wb_s2m_err (wb_s2m_err),
    .wb_s2m_rty (wb_s2m_rty)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("rdy_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cyc", 32'(wb_m2s_cyc), 32'd0);
    chk("rst_stb", 32'(wb_m2s_stb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_status", 32'(rsp_status), 32'd0);
    chk("rst_adr", wb_m2s_adr, 32'd0);
    wb_rst = 1'b0;
    tick();
    chk("idle_ready", 32'(req_ready), 32'd1);

    // Read 0x10, ack in first strobe cycle
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    chk("rd_cyc", 32'(wb_m2s_cyc), 32'd1);
    chk("rd_stb", 32'(wb_m2s_stb), 32'd1);
    chk("rd_adr", wb_m2s_adr, 32'h10);
    chk("rd_we", 32'(wb_m2s_we), 32'd0);
    chk("rd_busy", 32'(req_ready), 32'd0);
    chk("rd_novalid", 32'(rsp_valid), 32'd0);
    wb_s2m_ack = 1'b1;
    wb_s2m_dat = 32'hDEAD_BEEF;
    tick();
    wb_s2m_ack = 1'b0;
    chk("rd_cyc_drop", 32'(wb_m2s_cyc), 32'd0);
    chk("rd_valid", 32'(rsp_valid), 32'd1);
    chk("rd_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("rd_status", 32'(rsp_status), 32'(WBM_OK));
    respond();

    // Write 0x20 with 3 wait states; response held 5 cycles
    wb_s2m_dat = 32'hAAAA_5555;
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk("wr_cyc", 32'(wb_m2s_cyc), 32'd1);
      chk("wr_adr", wb_m2s_adr, 32'h20);
      chk("wr_dat", wb_m2s_dat, 32'h1234_5678);
      chk("wr_sel", 32'(wb_m2s_sel), 32'hF);
      chk("wr_we", 32'(wb_m2s_we), 32'd1);
      if (i == 3) wb_s2m_ack = 1'b1;
      tick();
    end
    wb_s2m_ack = 1'b0;
    chk("wr_cyc_drop", 32'(wb_m2s_cyc), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("wr_hold_valid", 32'(rsp_valid), 32'd1);
      chk("wr_hold_dat", rsp_dat, 32'd0);
      chk("wr_hold_status", 32'(rsp_status), 32'(WBM_OK));
      chk("wr_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    respond();

    // rty on every attempt: 4 bus cycles then RETRY
    issue(1'b0, 32'h0000_0030, 32'h0, 4'hF);
    for (int a = 0; a < 4; a++) begin
      chk("rty_cyc", 32'(wb_m2s_cyc), 32'd1);
      wb_s2m_rty = 1'b1;
      tick();
      wb_s2m_rty = 1'b0;
      if (a < 3) begin
        chk("rty_gap", 32'(wb_m2s_cyc), 32'd0);
        chk("rty_gap_rsp", 32'(rsp_valid), 32'd0);
        tick();
      end
    end
    chk("rty_valid", 32'(rsp_valid), 32'd1);
    chk("rty_status", 32'(rsp_status), 32'(WBM_RETRY));
    chk("rty_dat", rsp_dat, 32'd0);
    chk("rty_cyc_end", 32'(wb_m2s_cyc), 32'd0);
    respond();

    // rty twice, ack on third attempt
    issue(1'b0, 32'h0000_0034, 32'h0, 4'hF);
    for (int a = 0; a < 2; a++) begin
      wb_s2m_rty = 1'b1;
      tick();
      wb_s2m_rty = 1'b0;
      chk("rty2_gap", 32'(wb_m2s_cyc), 32'd0);
      tick();
    end
    chk("rty2_cyc3", 32'(wb_m2s_cyc), 32'd1);
    wb_s2m_ack = 1'b1;
    wb_s2m_dat = 32'hCAFE_F00D;
    tick();
    wb_s2m_ack = 1'b0;
    chk("rty2_valid", 32'(rsp_valid), 32'd1);
    chk("rty2_status", 32'(rsp_status), 32'(WBM_OK));
    chk("rty2_dat", rsp_dat, 32'hCAFE_F00D);
    respond();

    // No slave reply: cyc high exactly 16 cycles then TIMEOUT
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      chk("tmo_cyc", 32'(wb_m2s_cyc), 32'd1);
      chk("tmo_novalid", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("tmo_cyc_drop", 32'(wb_m2s_cyc), 32'd0);
    chk("tmo_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_status", 32'(rsp_status), 32'(WBM_TIMEOUT));
    chk("tmo_dat", rsp_dat, 32'd0);
    respond();

    // Next command after timeout runs normally
    issue(1'b0, 32'h0000_0044, 32'h0, 4'hF);
    chk("post_tmo_cyc", 32'(wb_m2s_cyc), 32'd1);
    wb_s2m_ack = 1'b1;
    wb_s2m_dat = 32'h1122_3344;
    tick();
    wb_s2m_ack = 1'b0;
    chk("post_tmo_status", 32'(rsp_status), 32'(WBM_OK));
    chk("post_tmo_dat", rsp_dat, 32'h1122_3344);
    respond();

    // ack and err together -> ERR
    issue(1'b0, 32'h0000_0048, 32'h0, 4'hF);
    wb_s2m_ack = 1'b1;
    wb_s2m_err = 1'b1;
    wb_s2m_dat = 32'h5555_AAAA;
    tick();
    wb_s2m_ack = 1'b0;
    wb_s2m_err = 1'b0;
    chk("ackerr_status", 32'(rsp_status), 32'(WBM_ERR));
    chk("ackerr_dat", rsp_dat, 32'd0);
    respond();

    // ack and rty together -> OK with data
    issue(1'b0, 32'h0000_0050, 32'h0, 4'hF);
    wb_s2m_ack = 1'b1;
    wb_s2m_rty = 1'b1;
    wb_s2m_dat = 32'h0BAD_F00D;
    tick();
    wb_s2m_ack = 1'b0;
    wb_s2m_rty = 1'b0;
    chk("ackrty_status", 32'(rsp_status), 32'(WBM_OK));
    chk("ackrty_dat", rsp_dat, 32'h0BAD_F00D);
    chk("ackrty_cyc", 32'(wb_m2s_cyc), 32'd0);
    respond();

    // Misaligned address -> ERR, no bus cycle, bus address untouched
    issue(1'b0, 32'h0000_0002, 32'h0, 4'hF);
    chk("mis_cyc", 32'(wb_m2s_cyc), 32'd0);
    chk("mis_valid", 32'(rsp_valid), 32'd1);
    chk("mis_status", 32'(rsp_status), 32'(WBM_ERR));
    chk("mis_adr", wb_m2s_adr, 32'h50);
    respond();
    chk("mis_cyc_after", 32'(wb_m2s_cyc), 32'd0);

    // Stray ack while idle is ignored
    wb_s2m_ack = 1'b1;
    tick();
    tick();
    wb_s2m_ack = 1'b0;
    chk("stray_valid", 32'(rsp_valid), 32'd0);
    chk("stray_cyc", 32'(wb_m2s_cyc), 32'd0);

    // Reset during a wait state drops the command
    issue(1'b0, 32'h0000_0060, 32'h0, 4'hF);
    tick();
    chk("mid_cyc", 32'(wb_m2s_cyc), 32'd1);
    wb_rst = 1'b1;
    tick();
    chk("mid_rst_cyc", 32'(wb_m2s_cyc), 32'd0);
    chk("mid_rst_stb", 32'(wb_m2s_stb), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    wb_rst = 1'b0;
    wb_s2m_ack = 1'b1;
    tick();
    wb_s2m_ack = 1'b0;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_cyc", 32'(wb_m2s_cyc), 32'd0);

    // Normal write after reset
    issue(1'b1, 32'h0000_0070, 32'h8765_4321, 4'h3);
    chk("fin_cyc", 32'(wb_m2s_cyc), 32'd1);
    chk("fin_sel", 32'(wb_m2s_sel), 32'h3);
    wb_s2m_ack = 1'b1;
    tick();
    wb_s2m_ack = 1'b0;
    chk("fin_status", 32'(rsp_status), 32'(WBM_OK));
    chk("fin_dat", rsp_dat, 32'd0);
    respond();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
